// File: rtl/router_input_port.sv
// Input port of the 5-port mesh router: flit FIFO, XY route computation on the
// head flit, and a wormhole request held toward a single output arbiter until
// the tail flit has been forwarded.
module router_input_port #(
  parameter int FLIT_W  = 32,
  parameter int DEPTH   = 4,
  parameter int COORD_W = 4,
  parameter int CUR_X   = 0,
  parameter int CUR_Y   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] in_flit,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [FLIT_W-1:0] out_flit,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        req_o,
  input  logic [4:0]        gnt_i,
  output logic              err_drop
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [2:0] P_LOCAL = 3'd0;
  localparam logic [2:0] P_EAST  = 3'd1;
  localparam logic [2:0] P_WEST  = 3'd2;
  localparam logic [2:0] P_NORTH = 3'd3;
  localparam logic [2:0] P_SOUTH = 3'd4;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  logic [FLIT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  state_t            state_q, state_d;
  logic [2:0]        port_q, port_d;
  logic [4:0]        req_q, req_d;
  logic              err_q, err_d;

  logic              empty, full, push, pop;
  logic [FLIT_W-1:0] head;
  logic              head_is_head, head_is_tail;
  logic [COORD_W-1:0] dx, dy;
  logic [2:0]        route_port;

  // FIFO status and head-flit field extraction
  always_comb begin
    empty        = (cnt_q == '0);
    full         = (cnt_q == CNT_W'(DEPTH));
    push         = in_valid && !full;
    head         = mem_q[rd_ptr_q];
    // type 01/11 start a packet, type 10/11 end one
    head_is_head = head[FLIT_W-2];
    head_is_tail = head[FLIT_W-1];
    dx           = head[2*COORD_W-1:COORD_W];
    dy           = head[COORD_W-1:0];
  end

  // XY dimension-order route: X is resolved before Y, unsigned compares
  always_comb begin
    if (dx > COORD_W'(CUR_X))      route_port = P_EAST;
    else if (dx < COORD_W'(CUR_X)) route_port = P_WEST;
    else if (dy > COORD_W'(CUR_Y)) route_port = P_NORTH;
    else if (dy < COORD_W'(CUR_Y)) route_port = P_SOUTH;
    else                           route_port = P_LOCAL;
  end

  // Packet FSM next-state: route on head, drop strays, forward while granted
  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    req_d   = req_q;
    err_d   = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_d = 5'b0;
        if (!empty) begin
          if (head_is_head) begin
            port_d  = route_port;
            req_d   = 5'b00001 << route_port;
            state_d = ACTIVE;
          end else begin
            pop   = 1'b1;
            err_d = 1'b1;
          end
        end
      end
      ACTIVE: begin
        // only the grant of our own arbiter counts; a lingering grant after
        // the tail cannot pop because we are back in IDLE by then
        if (gnt_i[port_q] && out_ready && !empty) begin
          pop = 1'b1;
          if (head_is_tail) begin
            state_d = IDLE;
            req_d   = 5'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 5'b0;
      end
    endcase
  end

  // FIFO pointer and occupancy next-state; a full FIFO refuses push even on pop
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Control registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      state_q  <= IDLE;
      port_q   <= P_LOCAL;
      req_q    <= 5'b0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      port_q   <= port_d;
      req_q    <= req_d;
      err_q    <= err_d;
    end
  end

  // Flit storage; contents need no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_flit;
  end

  // Output drive
  always_comb begin
    in_ready  = !full;
    out_flit  = head;
    out_valid = (state_q == ACTIVE) && !empty;
    req_o     = req_q;
    err_drop  = err_q;
  end

endmodule

// File: tb/tb_router_input_port.sv
// Bench for router_input_port (CUR=(1,1), DEPTH=4): route table, hand-written
// packet corner cases, then random traffic against a queue-based reference.
module tb_router_input_port;

  localparam int FLIT_W  = 32;
  localparam int DEPTH   = 4;
  localparam int COORD_W = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_flit;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_flit;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  req_o;
  logic [4:0]  gnt_i;
  logic        err_drop;

  // arbiter stand-in: registered grant echoing req, plus noise on other ports
  logic [4:0]  gnt_reg = 5'b0;
  logic [4:0]  noise;
  logic        gnt_en;

  router_input_port #(
    .FLIT_W(FLIT_W), .DEPTH(DEPTH), .COORD_W(COORD_W), .CUR_X(1), .CUR_Y(1)
  ) dut (
    .clk(clk), .rst(rst), .in_flit(in_flit), .in_valid(in_valid),
    .in_ready(in_ready), .out_flit(out_flit), .out_valid(out_valid),
    .out_ready(out_ready), .req_o(req_o), .gnt_i(gnt_i), .err_drop(err_drop)
  );

  always #5 clk = ~clk;

  always @(posedge clk) gnt_reg <= gnt_en ? req_o : 5'b0;
  assign gnt_i = gnt_reg | (noise & ~req_o);

  // reference state: flit queue and the output port held (-1 = no packet)
  logic [31:0] mq[$];
  int          cur;
  bit          exp_err;
  int          n_chk = 0;
  int          n_pass = 0;

  typedef struct {
    logic [3:0] dx;
    logic [3:0] dy;
    logic [4:0] req;
  } rvec_t;
  rvec_t tv[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic int route(input logic [3:0] dx, input logic [3:0] dy);
    if (dx > 4'd1) return 1;
    if (dx < 4'd1) return 2;
    if (dy > 4'd1) return 3;
    if (dy < 4'd1) return 4;
    return 0;
  endfunction

  function automatic logic [31:0] mk(input logic [1:0] t, input logic [3:0] dx, input logic [3:0] dy);
    logic [31:0] f;
    f = $urandom;
    f[31:30] = t;
    f[7:4]   = dx;
    f[3:0]   = dy;
    return f;
  endfunction

  // advance one clock: update the reference from the inputs now applied, then
  // compare every DUT output #1 after the edge
  task automatic step();
    int nxt;
    int sz0;
    bit pop;
    logic [1:0] t;
    #1;
    nxt = cur;
    pop = 0;
    exp_err = 0;
    sz0 = mq.size();
    if (rst) begin
      mq.delete();
      nxt = -1;
    end else begin
      if (cur < 0) begin
        if (sz0 > 0) begin
          t = mq[0][31:30];
          if (t[0]) nxt = route(mq[0][7:4], mq[0][3:0]);
          else begin pop = 1; exp_err = 1; end
        end
      end else if (gnt_i[cur] && out_ready && sz0 > 0) begin
        pop = 1;
        t = mq[0][31:30];
        if (t[1]) nxt = -1;
      end
      if (pop) void'(mq.pop_front());
      if (in_valid && sz0 < DEPTH) mq.push_back(in_flit);
    end
    cur = nxt;
    @(posedge clk);
    #1;
    chk("req_o", {27'b0, req_o}, (cur < 0) ? 32'd0 : (32'd1 << cur));
    chk("in_ready", {31'b0, in_ready}, {31'b0, (mq.size() < DEPTH)});
    chk("out_valid", {31'b0, out_valid}, {31'b0, (cur >= 0 && mq.size() > 0)});
    chk("err_drop", {31'b0, err_drop}, {31'b0, exp_err});
    if (mq.size() > 0) chk("out_flit", out_flit, mq[0]);
  endtask

  initial begin
    int cnt;
    bit done;
    logic [1:0] t;

    tv[0] = '{4'd3, 4'd1, 5'b00010};
    tv[1] = '{4'd0, 4'd2, 5'b00100};
    tv[2] = '{4'd1, 4'd1, 5'b00001};
    tv[3] = '{4'd1, 4'd0, 5'b10000};
    tv[4] = '{4'd2, 4'd0, 5'b00010};
    tv[5] = '{4'd1, 4'd2, 5'b01000};
    tv[6] = '{4'd0, 4'd0, 5'b00100};
    tv[7] = '{4'd15, 4'd15, 5'b00010};
    tv[8] = '{4'd1, 4'd15, 5'b01000};
    tv[9] = '{4'd0, 4'd15, 5'b00100};

    rst = 1; in_valid = 0; in_flit = 0; out_ready = 0; gnt_en = 0; noise = 0;
    cur = -1;
    step(); step();
    rst = 0;
    step();
    chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
    chk("reset_req", {27'b0, req_o}, 32'd0);

    // route table: single flit, request two edges after push, pop on grant
    for (int i = 0; i < 10; i++) begin
      in_valid = 1; in_flit = mk(2'b11, tv[i].dx, tv[i].dy);
      step();
      in_valid = 0;
      step();
      chk("route_req", {27'b0, req_o}, {27'b0, tv[i].req});
      gnt_en = 1; out_ready = 1;
      step();
      step();
      chk("route_req_drop", {27'b0, req_o}, 32'd0);
      step();
      gnt_en = 0; out_ready = 0;
    end

    // 4-flit packet to the west, followed by a local single that must not be
    // popped by the stale west grant
    gnt_en = 1; out_ready = 1; cnt = 0;
    for (int i = 0; i < 9; i++) begin
      in_valid = (i < 5);
      case (i)
        0:       in_flit = mk(2'b01, 4'd0, 4'd2);
        1, 2:    in_flit = mk(2'b00, 4'd9, 4'd9);
        3:       in_flit = mk(2'b10, 4'd9, 4'd9);
        default: in_flit = mk(2'b11, 4'd1, 4'd1);
      endcase
      step();
      if (req_o == 5'b00100) cnt++;
    end
    chk("pkt_req_cycles", cnt, 32'd5);
    in_valid = 0;
    repeat (4) step();

    // fill the FIFO while downstream stalls; fifth flit waits upstream
    out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1;
      in_flit = (i == 0) ? mk(2'b01, 4'd3, 4'd1) : mk(2'b00, 4'd5, 4'd5);
      step();
    end
    chk("full_in_ready", {31'b0, in_ready}, 32'd0);
    in_flit = mk(2'b10, 4'd5, 4'd5);
    step(); step();
    chk("full_hold", {31'b0, in_ready}, 32'd0);
    out_ready = 1;
    step();
    chk("ready_after_pop", {31'b0, in_ready}, 32'd1);
    done = 0;
    for (int i = 0; i < 10 && !done; i++) begin
      done = in_ready;
      step();
    end
    chk("held_flit_accepted", {31'b0, done}, 32'd1);
    in_valid = 0;
    repeat (6) step();

    // stray body flit while idle, then a normal head
    in_valid = 1; in_flit = mk(2'b00, 4'd3, 4'd3);
    step();
    in_valid = 0;
    step();
    chk("err_pulse", {31'b0, err_drop}, 32'd1);
    chk("err_req", {27'b0, req_o}, 32'd0);
    step();
    chk("err_pulse_end", {31'b0, err_drop}, 32'd0);
    in_valid = 1; in_flit = mk(2'b11, 4'd1, 4'd0);
    step();
    in_valid = 0;
    step();
    chk("after_err_route", {27'b0, req_o}, 32'b10000);
    repeat (4) step();

    // reset with two flits of a packet buffered
    out_ready = 0;
    in_valid = 1; in_flit = mk(2'b01, 4'd0, 4'd0);
    step();
    in_flit = mk(2'b00, 4'd0, 4'd0);
    step();
    in_valid = 0;
    step();
    rst = 1;
    step();
    chk("rst_req", {27'b0, req_o}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    rst = 0;
    step();

    // random traffic including stray flits, noisy grants and rare resets
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 299) == 0);
      in_valid  = ($urandom_range(0, 99) < 60);
      case ($urandom_range(0, 9))
        0, 1, 2:    t = 2'b01;
        3, 4, 5:    t = 2'b00;
        6, 7:       t = 2'b10;
        default:    t = 2'b11;
      endcase
      in_flit   = mk(t, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      out_ready = ($urandom_range(0, 99) < 75);
      gnt_en    = ($urandom_range(0, 99) < 80);
      noise     = 5'($urandom);
      step();
    end
    rst = 0; in_valid = 0; out_ready = 1; gnt_en = 1; noise = 0;
    repeat (20) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/router_input_port.md
Name: router_input_port

Overview:
- Input-port unit of the 5-port mesh router; sits directly upstream of the five per-output-port round-hold arbiters.
- Buffers incoming flits in a small FIFO and computes the XY route from the head flit.
- Holds a one-hot request toward exactly one output arbiter for the whole packet (wormhole).
- Forwards flits to the crossbar while its grant is held; drops the request after the tail flit leaves.

Parameters:
- FLIT_W, 32, flit width in bits, including the 2-bit type field.
- DEPTH, 4, FIFO depth in flits (power of 2, ≥2).
- COORD_W, 4, width of each X/Y coordinate.
- CUR_X, 0, X coordinate of this router.
- CUR_Y, 0, Y coordinate of this router.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_flit  in  FLIT_W  flit from the upstream link
- in_valid  in  1  in_flit is valid
- in_ready  out  1  FIFO can accept; equals !full
- out_flit  out  FLIT_W  FIFO head flit, to the crossbar
- out_valid  out  1  FIFO non-empty and state ACTIVE
- out_ready  in  1  downstream link can accept a flit this cycle
- req_o  out  5  one-hot request, bit k goes to output arbiter k: 0=local, 1=east, 2=west, 3=north, 4=south
- gnt_i  in  5  grants collected from the 5 output arbiters, bit k from arbiter k
- err_drop  out  1  one-cycle pulse when a stray non-head flit is discarded

Behaviour:
- Flit type is in_flit[FLIT_W-1:FLIT_W-2]:
  - 01 = head, 00 = body, 10 = tail, 11 = single (head and tail).
- Head/single flits carry destination X in [2*COORD_W-1:COORD_W] and destination Y in [COORD_W-1:0].
- FIFO:
  - Push when in_valid && in_ready.
  - A push is refused when full, even if a pop occurs in the same cycle.
  - Pop and push in the same cycle are allowed when not full; count is unchanged.
  - Pointers wrap modulo DEPTH.
  - out_flit always shows the FIFO head.
- Reset: FIFO empty, state IDLE, req_o=0, out_valid=0, err_drop=0, in_ready=1.
- FSM states:
  - IDLE:
    - FIFO empty → stay.
    - Head is type head/single → register the route port, go to ACTIVE.
    - Head is type body/tail → pop it, pulse err_drop, stay in IDLE.
  - ACTIVE:
    - req_o = one-hot of the registered port.
    - Pop when gnt_i[port] && out_ready && FIFO non-empty.
    - Popped flit type tail or single → go to IDLE; req_o is 0 from the next cycle.
    - Otherwise stay in ACTIVE.
    - FIFO empty mid-packet → hold req_o; out_valid=0, no pop.
- XY route, evaluated in IDLE on the head flit:
  - dx>CUR_X → east.
  - dx<CUR_X → west.
  - Otherwise dy>CUR_Y → north; dy<CUR_Y → south.
  - Otherwise local.
  - Comparisons are unsigned.
- Grant handling:
  - Pops happen only in ACTIVE, and only on the grant bit of the registered port; all other gnt_i bits are ignored.
  - The arbiter's grant lingers one cycle after req_o falls; that stale grant must not cause a pop because the state is already IDLE.
- Latency:
  - Flit pushed at edge t → IDLE sees it during cycle t.
  - ACTIVE and req_o high after edge t+1.
  - Registered arbiter grant visible after edge t+2.
  - First pop at edge t+3 if out_ready=1.
  - After that, one flit per cycle while gnt_i and out_ready both hold.
- Reset mid-packet discards the FIFO and returns to IDLE; req_o drops the cycle after rst is sampled.

Test Plan:
- CUR=(1,1), push single flit dest (3,1) → req_o=00010 two cycles after push; with gnt_i[1] returned one cycle later, popped next edge; req_o=00000 the cycle after.
- CUR=(1,1), head dest (0,2) + 2 body + tail, gnt_i[2] held → req_o=00100 throughout; 4 consecutive pops; req_o drops after the tail pop; the stale gnt in the following cycle does not pop a new flit.
- Dest (1,1) single flit → req_o=00001. Dest (1,0) → req_o=10000. Dest (2,0) → east, i.e. X is resolved first.
- DEPTH=4, out_ready=0, push 5 flits back-to-back → in_ready=0 after the 4th; the 5th is held upstream; raising out_ready pops in order and in_ready=1 after the first pop.
- Body flit arrives while IDLE → popped, err_drop high for exactly 1 cycle, req_o stays 0; a following head flit routes normally.
- rst asserted mid-packet with 2 flits buffered → next cycle FIFO empty, req_o=0, in_ready=1, state IDLE.
